// File: rtl/riscv_pkg.sv
// ----------------------------------------------------------------------------
// riscv_pkg : shared encodings for the memory-port arbiter
// Revision  : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package riscv_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_e;

  localparam int unsigned MEM_LAT_DEF = 1;

endpackage

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// ----------------------------------------------------------------------------
// mem_port_arbiter : shares one SRAM port between fetch (I) and load/store (D)
// Revision         : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module mem_port_arbiter
  import riscv_pkg::*;
#(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned MEM_LAT    = MEM_LAT_DEF,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic                i_gnt,
  output logic                i_rvalid,
  output logic [DATA_W-1:0]   i_rdata,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_wstrb,
  output logic                d_gnt,
  output logic                d_rvalid,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                m_en,
  output logic                m_we,
  output logic [ADDR_W-1:0]   m_addr,
  output logic [DATA_W-1:0]   m_wdata,
  output logic [DATA_W/8-1:0] m_wstrb,
  input  logic [DATA_W-1:0]   m_rdata
);

  localparam int unsigned LAT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT + 1) : 1;
  localparam int unsigned CNT_W = (STARVE_MAX > 1) ? $clog2(STARVE_MAX + 1) : 1;
  localparam logic [LAT_W-1:0] C_LAT_INIT = LAT_W'(MEM_LAT);
  localparam logic [LAT_W-1:0] C_LAT_ONE  = LAT_W'(1);
  localparam logic [CNT_W-1:0] C_STARVE   = CNT_W'(STARVE_MAX);

  state_e            state_q;
  owner_e            owner_q;
  logic [LAT_W-1:0]  lat_q;
  logic [CNT_W-1:0]  starve_q;
  logic              drop_q;

  logic w_idle, w_d_win, w_i_win, w_rd_done, w_d_store;

  // Every output is gated by rst_n so nothing leaks while reset is held.
  always_comb begin
    w_idle    = rst_n && (state_q == ST_IDLE);
    w_d_win   = w_idle && d_req && ((starve_q < C_STARVE) || !i_req || flush);
    w_i_win   = w_idle && !w_d_win && i_req && !flush;
    w_d_store = w_d_win && d_we;
    w_rd_done = rst_n && (state_q == ST_BUSY) && (lat_q == C_LAT_ONE);
  end

  always_comb begin
    i_gnt    = w_i_win;
    d_gnt    = w_d_win;
    m_en     = w_d_win || w_i_win;
    m_we     = w_d_store;
    m_addr   = w_d_win ? d_addr : (w_i_win ? i_addr : '0);
    m_wdata  = w_d_store ? d_wdata : '0;
    m_wstrb  = w_d_store ? d_wstrb : '0;
    i_rvalid = w_rd_done && (owner_q == OWN_I) && !drop_q && !flush;
    d_rvalid = w_rd_done && (owner_q == OWN_D);
    i_rdata  = i_rvalid ? m_rdata : '0;
    d_rdata  = d_rvalid ? m_rdata : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      owner_q  <= OWN_D;
      lat_q    <= '0;
      starve_q <= '0;
      drop_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (w_i_win || (w_d_win && !d_we)) begin
            state_q <= ST_BUSY;
            owner_q <= w_i_win ? OWN_I : OWN_D;
            lat_q   <= C_LAT_INIT;
            drop_q  <= 1'b0;
          end
        end
        ST_BUSY: begin
          lat_q <= lat_q - C_LAT_ONE;
          if (flush && (owner_q == OWN_I)) begin
            drop_q <= 1'b1;
          end
          if (lat_q == C_LAT_ONE) begin
            state_q <= ST_IDLE;
            drop_q  <= 1'b0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase

      // Fetch fairness: saturating count of D wins while fetch is waiting.
      if (!i_req || w_i_win) begin
        starve_q <= '0;
      end else if (w_d_win && (starve_q != C_STARVE)) begin
        starve_q <= starve_q + CNT_W'(1);
      end
    end
  end

endmodule

`default_nettype wire

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbitrates the single-ported data/instruction SRAM between the fetch stage (I-port) and the execute-stage load/store path (D-port). It accepts one request per free cycle and drives the shared memory port for the winning requester. It then times the fixed memory read latency and returns read data to the owning requester with a one-cycle valid pulse. It sits between the pipeline stages and the memory macro, and enforces priority for the D-port plus a starvation guard for fetch.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- MEM_LAT, 1, SRAM read latency in cycles (≥1)
- STARVE_MAX, 4, consecutive D-grants allowed while I-port waits

- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- flush  in  1  pipeline flush; drops outstanding fetch response, blocks fetch grants
- i_req  in  1  fetch read request, held until granted
- i_addr  in  ADDR_W  fetch address
- i_gnt  out  1  fetch request accepted this cycle
- i_rvalid  out  1  fetch data valid pulse
- i_rdata  out  DATA_W  fetch data
- d_req  in  1  data request, held until granted
- d_we  in  1  1=store, 0=load
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_wstrb  in  DATA_W/8  store byte enables
- d_gnt  out  1  data request accepted this cycle
- d_rvalid  out  1  load data valid pulse
- d_rdata  out  DATA_W  load data
- m_en  out  1  SRAM access enable
- m_we  out  1  SRAM write enable
- m_addr  out  ADDR_W  SRAM address
- m_wdata  out  DATA_W  SRAM write data
- m_wstrb  out  DATA_W/8  SRAM byte enables
- m_rdata  in  DATA_W  SRAM read data, valid MEM_LAT cycles after m_en

## Operation
- States: IDLE, BUSY. One read outstanding at most. Writes never enter BUSY.
- IDLE grant selection, evaluated combinationally:
  - D wins if d_req and (starve_cnt < STARVE_MAX or !i_req or flush).
  - Otherwise I wins if i_req and !flush.
- Grant cycle: the gnt signal, m_en, and the m_* fields are driven combinationally from the winner in the same cycle. m_wstrb=0 and m_we=0 for reads.
- Read grant: latch owner, set lat_cnt=MEM_LAT, go BUSY.
- Store grant: stay IDLE. A back-to-back grant is allowed on the next cycle. No rvalid is issued for stores.
- BUSY: no grants. lat_cnt decrements each cycle. The cycle where lat_cnt==1 asserts rvalid to the owner with rdata=m_rdata, and the next state is IDLE.
- Read data muxes (i_rdata, d_rdata) pass m_rdata; they are 0 whenever the matching rvalid is 0.
- starve_cnt:
  - +1 (saturating at STARVE_MAX) on each D grant while i_req=1.
  - Cleared on an I grant, or on any cycle with i_req=0.
- flush:
  - An owner=I read that is in BUSY completes its latency, but i_rvalid is suppressed. This holds if flush is seen at any cycle from the grant through the rvalid cycle; a sticky drop bit is cleared on return to IDLE.
  - D transactions are unaffected.
- No address checking. Alignment and access faults are raised upstream.

## Timing
- Reset: state=IDLE, lat_cnt=0, owner=D, starve_cnt=0, drop=0. All outputs are 0 while in reset.
- Read latency: gnt at cycle T, rvalid at T+MEM_LAT, next grant possible at T+MEM_LAT+1.
- Store: gnt and SRAM write both occur at T. The next grant is possible at T+1.
- Simultaneous d_req and i_req at the STARVE_MAX threshold: I wins, and starve_cnt clears.
- Async reset mid-BUSY: the transaction is abandoned and no rvalid is issued.
- A requester must hold req and payload stable until gnt.

## Structure
- Shared package riscv_pkg holds:
  - the state encoding (ST_IDLE, ST_BUSY)
  - the owner encoding (OWN_I, OWN_D)
  - the default MEM_LAT constant
- Single module. No sub-module is needed. starve_cnt and lat_cnt stay inline.

## Test plan
- Lone fetch, MEM_LAT=1: i_req at addr 0x100 at cycle 2 -> i_gnt=1 and m_en=1 with m_addr=0x100 at cycle 2, i_rvalid=1 with i_rdata=m_rdata at cycle 3, i_req re-granted at cycle 4.
- Contention: d_req load 0x2000 and i_req both high -> d_gnt first, i_gnt only after d_rvalid, and never both in one cycle.
- Starvation: d_req held high with back-to-back stores, i_req high -> exactly 4 d_gnt, then i_gnt on the 5th grant, then starve_cnt=0.
- Store streaming: 3 stores with d_wstrb=4'b0011 -> d_gnt on 3 consecutive cycles, m_we=1, m_wstrb=0011, no d_rvalid.
- Flush: fetch granted at T with MEM_LAT=2, flush at T+1 -> no i_rvalid, IDLE at T+3, a pending d_req granted at T+3.
- Reset mid-read: rst_n low at T+1 after a D read grant -> all outputs 0, no d_rvalid after release, and a new grant accepted on the first cycle out of reset.
